prio_req_dispatch: RTL
======================

PRIO_REQ_DISPATCH -- requirements
Module: prio_req_dispatch

Interface
REQ-001 Parameter: DROP_W, default 8, width of the saturating drop counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_in  input  4  request pulses; bit i high for one cycle = one request from source i.
REQ-005 out_ready  input  1  downstream accepts out_pos when high with out_valid.
REQ-006 out_valid  output  1  out_pos holds a dispatched source index.
REQ-007 out_pos  output  2  index of the dispatched source.
REQ-008 pending  output  4  sticky pending-request register, bit i = source i awaiting dispatch.
REQ-009 busy  output  1  high when pending != 0 or out_valid == 1.
REQ-010 drop_cnt  output  DROP_W  saturating count of requests merged into an already-pending bit.

Function
REQ-011 Pending update each cycle SHALL be: pending_next = (pending & ~load_mask) | req_in; load_mask is one-hot of the index loaded this cycle, else 0.
REQ-012 Selection SHALL be lowest-index-first: bit 0 highest priority, bit 3 lowest; selection uses the registered pending value only, never same-cycle req_in.
REQ-013 Output slot SHALL be a two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-014 EMPTY: if pending != 0, load selected index into out_pos, set out_valid, go FULL; else stay EMPTY.
REQ-015 FULL with out_ready=0: out_pos and out_valid SHALL hold unchanged; no load.
REQ-016 FULL with out_ready=1: handshake completes; if pending != 0, load next selected index same cycle and stay FULL (back-to-back, no bubble); else clear out_valid, go EMPTY.
REQ-017 Latency: req_in pulse at edge N visible in pending after N; out_valid earliest after edge N+1 (2-cycle req-to-valid with empty pipeline).
REQ-018 A request for bit i arriving in the same cycle bit i is loaded SHALL set pending[i] again (new request, not a drop).
REQ-019 Drop: req_in[i]=1 while pending[i]=1 and i not loaded this cycle SHALL increment drop_cnt by 1 per such bit (0-4 per cycle).
REQ-020 drop_cnt SHALL saturate at 2^DROP_W-1 and never wrap.
REQ-021 A request for index equal to the current out_pos while FULL SHALL set pending normally (dispatched again later).
REQ-022 out_pos SHALL read 0 whenever out_valid=0.
REQ-023 busy SHALL be combinational from registered pending and out_valid.

Reset
REQ-024 On reset high at an edge: pending=0, out_valid=0, out_pos=0, drop_cnt=0, FSM=EMPTY; req_in in that cycle SHALL be ignored.
REQ-025 Reset mid-handshake SHALL discard the held out_pos and all pending requests; nothing replays after release.
REQ-026 Reset held multiple cycles SHALL keep all outputs at reset values.

Verification
REQ-027 Single request: req_in=4'b0100 one cycle, out_ready=1 -> out_valid high 2 cycles later with out_pos=2 for exactly one cycle; pending returns 0, busy drops.
REQ-028 Priority order: req_in=4'b1111 one cycle, out_ready=1 -> out_pos sequence 0,1,2,3 on four consecutive cycles, no bubbles, drop_cnt=0.
REQ-029 Backpressure: req_in=4'b1010, out_ready=0 for 5 cycles -> out_pos=1 held stable, pending=4'b1000; raise out_ready -> 1 then 3.
REQ-030 Drops: pending[0]=1 with output held (out_ready=0), req_in=4'b0001 for 3 cycles -> drop_cnt=3; with DROP_W=2, 5 such cycles -> drop_cnt=3 (saturated).
REQ-031 Reload collision: out_valid=0, pending=4'b0001, req_in=4'b0001 same cycle -> out_pos=0 loaded, pending[0] stays 1, drop_cnt unchanged, second dispatch of 0 follows.
REQ-032 Reset mid-operation: pending=4'b1110, out_valid=1, out_ready=0, assert reset one cycle -> all outputs 0 next cycle; no out_valid after release without new requests.

Source files
------------

// File: rtl/prio_req_dispatch.sv
// Four-source request collector with a lowest-index-first dispatcher feeding a
// single-entry valid/ready output slot, plus a saturating count of merged requests.
module prio_req_dispatch #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_pos,
  output logic [3:0]        pending,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int SUM_W = DROP_W + 3;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [1:0]        pos_q, pos_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              any_pend;
  logic [1:0]        sel;
  logic              load;
  logic [3:0]        load_mask;
  logic [3:0]        drop_bits;
  logic [2:0]        drop_inc;
  logic [SUM_W-1:0]  drop_sum;

  assign any_pend = |pending_q;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) sel = 2'(i);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    load    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (any_pend) begin
          load    = 1'b1;
          pos_d   = sel;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (any_pend) begin
            load  = 1'b1;
            pos_d = sel;
          end else begin
            pos_d   = 2'd0;
            state_d = EMPTY;
          end
        end
      end
      default: begin
        pos_d   = 2'd0;
        state_d = EMPTY;
      end
    endcase
  end

  // A request landing on the bit being loaded is a fresh request, not a drop.
  always_comb begin
    load_mask = load ? (4'b0001 << sel) : 4'b0000;
    pending_d = (pending_q & ~load_mask) | req_in;
    drop_bits = req_in & pending_q & ~load_mask;
    drop_inc  = {2'b00, drop_bits[0]} + {2'b00, drop_bits[1]}
              + {2'b00, drop_bits[2]} + {2'b00, drop_bits[3]};
    drop_sum  = SUM_W'(drop_q) + SUM_W'(drop_inc);
    drop_d    = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      pending_q <= 4'b0000;
      pos_q     <= 2'd0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pos_q     <= pos_d;
      drop_q    <= drop_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_pos   = pos_q;
  assign pending   = pending_q;
  assign busy      = any_pend | out_valid;
  assign drop_cnt  = drop_q;

endmodule
